// File: rtl/bias_add_quant_pkg.sv
// -----------------------------------------------------------------------------
// bias_add_quant_pkg
// Shared definitions for the bias-add / requantise stage:
//   state_t         - control FSM states (IDLE, WAIT_BIAS, RUN, DRAIN)
//   QUANT_W         - width of the intermediate rounding/shift arithmetic
//   sat_hi / sat_lo - signed saturation bounds for an OUT_LEN-bit result
// -----------------------------------------------------------------------------
package bias_add_quant_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BIAS = 2'd1,
        RUN       = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    // Wide enough for a 2^30 rounding constant on top of any psum+bias sum.
    localparam int QUANT_W = 64;

    function automatic logic signed [QUANT_W-1:0] sat_hi(input int out_len);
        return (64'sd1 <<< (out_len - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [QUANT_W-1:0] sat_lo(input int out_len);
        return -(64'sd1 <<< (out_len - 1));
    endfunction

endpackage

// File: rtl/bias_add_quant_if.sv
// -----------------------------------------------------------------------------
// bias_add_quant_if
// Bus bundle of the bias-add / requantise stage.
//   bias bus   : bias_rd_conf (request), bias_in + bias_en (response)
//   psum in    : psum_in, psum_valid, psum_ready (valid/ready)
//   result out : data_out, out_valid, out_ready (valid/ready)
// Modports: slave = the stage itself, master = the surrounding system.
// -----------------------------------------------------------------------------
interface bias_add_quant_if #(
    parameter int X_PE         = 16,
    parameter int BIAS_DATALEN = 20,
    parameter int PSUM_LEN     = 24,
    parameter int OUT_LEN      = 8
);
    logic                           bias_rd_conf;
    logic [X_PE*BIAS_DATALEN-1:0]   bias_in;
    logic                           bias_en;
    logic [X_PE*PSUM_LEN-1:0]       psum_in;
    logic                           psum_valid;
    logic                           psum_ready;
    logic [X_PE*OUT_LEN-1:0]        data_out;
    logic                           out_valid;
    logic                           out_ready;

    modport slave (
        output bias_rd_conf,
        input  bias_in, bias_en,
        input  psum_in, psum_valid,
        output psum_ready,
        output data_out, out_valid,
        input  out_ready
    );

    modport master (
        input  bias_rd_conf,
        output bias_in, bias_en,
        output psum_in, psum_valid,
        input  psum_ready,
        input  data_out, out_valid,
        output out_ready
    );
endinterface

// File: rtl/bias_quant_lane.sv
// -----------------------------------------------------------------------------
// bias_quant_lane
// One channel of the datapath: stage 1 adds psum + bias at PSUM_LEN+1 bits,
// stage 2 rounds half-up, arithmetic-shifts right by shift and saturates to
// OUT_LEN bits. With BIAS_ADD_RELU_EN defined, negative results clamp to 0
// (same latency either way).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   ld1         - load stage-1 sum register (psum accepted)
//   ld2         - load stage-2 output register (pipeline advancing a valid sum)
//   psum, bias  - signed channel operands
//   shift       - right-shift amount latched for the tile
//   q           - registered quantised result
// -----------------------------------------------------------------------------
module bias_quant_lane
    import bias_add_quant_pkg::*;
#(
    parameter int BIAS_DATALEN = 20,
    parameter int PSUM_LEN     = 24,
    parameter int OUT_LEN      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld1,
    input  logic                 ld2,
    input  logic [PSUM_LEN-1:0]  psum,
    input  logic [BIAS_DATALEN-1:0] bias,
    input  logic [4:0]           shift,
    output logic [OUT_LEN-1:0]   q
);
    localparam int SW = PSUM_LEN + 1;
    localparam logic signed [QUANT_W-1:0] SAT_HI = sat_hi(OUT_LEN);
    localparam logic signed [QUANT_W-1:0] SAT_LO = sat_lo(OUT_LEN);

    logic signed [SW-1:0]      sum_reg;
    logic signed [SW-1:0]      sum_next;
    logic signed [QUANT_W-1:0] wide;
    logic signed [QUANT_W-1:0] rnd;
    logic signed [QUANT_W-1:0] shifted;
    logic        [OUT_LEN-1:0] res;

    always_comb begin
        sum_next = $signed({psum[PSUM_LEN-1], psum})
                 + $signed({{(SW-BIAS_DATALEN){bias[BIAS_DATALEN-1]}}, bias});
    end

    always_comb begin
        wide = {{(QUANT_W-SW){sum_reg[SW-1]}}, sum_reg};
        rnd  = '0;
        if (shift != 5'd0) begin
            rnd = 64'sd1 <<< (shift - 5'd1);
        end
        shifted = (wide + rnd) >>> shift;
        res     = shifted[OUT_LEN-1:0];
        if (shifted > SAT_HI) begin
            res = SAT_HI[OUT_LEN-1:0];
        end else if (shifted < SAT_LO) begin
            res = SAT_LO[OUT_LEN-1:0];
        end
`ifdef BIAS_ADD_RELU_EN
        if (res[OUT_LEN-1]) begin
            res = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
            q       <= '0;
        end else begin
            if (ld1) begin
                sum_reg <= sum_next;
            end
            if (ld2) begin
                q <= res;
            end
        end
    end
endmodule

// File: rtl/bias_add_quant.sv
// -----------------------------------------------------------------------------
// bias_add_quant
// Per-tile bias add + requantisation of X_PE parallel psum channels.
// A tile starts with a one-cycle start pulse (tile_len, out_shift sampled),
// requests the bias vector once, streams tile_len psum vectors through a
// 2-stage pipeline and pulses done after the last result is taken.
// Optional macro: BIAS_ADD_RELU_EN (clamp negative results to 0).
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - one-cycle tile start (honoured only in IDLE)
//   tile_len          - psum vectors in the tile (0 = empty tile)
//   out_shift         - rounding right-shift amount
//   busy              - high when not IDLE
//   done              - one-cycle tile-complete pulse
//   bus (slave)       - bias bus, psum input stream, result output stream
// -----------------------------------------------------------------------------
module bias_add_quant
    import bias_add_quant_pkg::*;
#(
    parameter int X_PE         = 16,
    parameter int BIAS_DATALEN = 20,
    parameter int PSUM_LEN     = 24,
    parameter int OUT_LEN      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] tile_len,
    input  logic [4:0]  out_shift,
    output logic        busy,
    output logic        done,
    bias_add_quant_if.slave bus
);
    state_t state_reg, state_next;

    logic [15:0]                  len_reg;
    logic [15:0]                  cnt_reg;
    logic [4:0]                   shift_reg;
    logic [X_PE*BIAS_DATALEN-1:0] bias_reg;
    logic                         s1_valid_reg;
    logic                         out_valid_reg;
    logic                         done_reg, done_next;
    logic                         rd_conf_reg, rd_conf_next;
    logic                         adv;
    logic                         accept;
    logic                         out_fire;
    logic                         ld2;
    logic [X_PE*OUT_LEN-1:0]      data_out_w;

    // Whole pipeline freezes while a result waits for out_ready.
    assign adv      = !out_valid_reg || bus.out_ready;
    assign accept   = bus.psum_valid && bus.psum_ready;
    assign out_fire = out_valid_reg && bus.out_ready;
    assign ld2      = adv && s1_valid_reg;

    assign bus.psum_ready   = (state_reg == RUN) && adv;
    assign bus.out_valid    = out_valid_reg;
    assign bus.data_out     = data_out_w;
    assign bus.bias_rd_conf = rd_conf_reg;
    assign busy             = (state_reg != IDLE);
    assign done             = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        done_next    = 1'b0;
        rd_conf_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (tile_len != 16'd0) begin
                        state_next   = WAIT_BIAS;
                        rd_conf_next = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            WAIT_BIAS: begin
                if (bus.bias_en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && (cnt_reg + 16'd1 == len_reg)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Last result leaves with nothing left behind it in stage 1.
                if (out_fire && !s1_valid_reg) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg       <= '0;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            bias_reg      <= '0;
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            rd_conf_reg   <= 1'b0;
        end else begin
            done_reg    <= done_next;
            rd_conf_reg <= rd_conf_next;
            if (state_reg == IDLE && start) begin
                len_reg   <= tile_len;
                shift_reg <= out_shift;
                cnt_reg   <= '0;
            end
            if (state_reg == WAIT_BIAS && bus.bias_en) begin
                bias_reg <= bus.bias_in;
            end
            if (accept) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
            if (adv) begin
                s1_valid_reg  <= accept;
                out_valid_reg <= s1_valid_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < X_PE; gi++) begin : g_lane
            bias_quant_lane #(
                .BIAS_DATALEN (BIAS_DATALEN),
                .PSUM_LEN     (PSUM_LEN),
                .OUT_LEN      (OUT_LEN)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .ld1   (accept),
                .ld2   (ld2),
                .psum  (bus.psum_in[gi*PSUM_LEN +: PSUM_LEN]),
                .bias  (bias_reg[gi*BIAS_DATALEN +: BIAS_DATALEN]),
                .shift (shift_reg),
                .q     (data_out_w[gi*OUT_LEN +: OUT_LEN])
            );
        end
    endgenerate
endmodule

// File: tb/tb_bias_add_quant.sv
module tb_bias_add_quant;
    localparam int X_PE         = 16;
    localparam int BIAS_DATALEN = 20;
    localparam int PSUM_LEN     = 24;
    localparam int OUT_LEN      = 8;
    localparam int DW           = X_PE * OUT_LEN;
    localparam int BW           = X_PE * BIAS_DATALEN;
    localparam int PW           = X_PE * PSUM_LEN;

    typedef struct {
        logic [DW-1:0] data;
        int            acc_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] tile_len;
    logic [4:0]  out_shift;
    logic        busy;
    logic        done;

    bias_add_quant_if #(
        .X_PE(X_PE), .BIAS_DATALEN(BIAS_DATALEN), .PSUM_LEN(PSUM_LEN), .OUT_LEN(OUT_LEN)
    ) bus ();

    bias_add_quant #(
        .X_PE(X_PE), .BIAS_DATALEN(BIAS_DATALEN), .PSUM_LEN(PSUM_LEN), .OUT_LEN(OUT_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tile_len  (tile_len),
        .out_shift (out_shift),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   last_fire_cyc = -100;
    int   done_cnt = 0;
    int   rd_cnt = 0;
    int   rdy_mode = 0;
    bit   lat_check = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact rational arithmetic, round half up, floor division.
    function automatic logic [OUT_LEN-1:0] ref_q(input longint p, input longint b, input int sh);
        longint s, d, n, q, hi, lo;
        s  = p + b;
        hi = (longint'(1) << (OUT_LEN - 1)) - 1;
        lo = -hi - 1;
        if (sh == 0) begin
            q = s;
        end else begin
            d = longint'(1) << sh;
            n = s + d / 2;
            q = n / d;
            if ((n % d != 0) && (n < 0)) q = q - 1;
        end
        if (q > hi) q = hi;
        if (q < lo) q = lo;
`ifdef BIAS_ADD_RELU_EN
        if (q < 0) q = 0;
`endif
        return q[OUT_LEN-1:0];
    endfunction

    // out_ready driver: 0 = always high, 1 = toggling, 2 = random (75% high)
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.out_ready = !bus.out_ready;
                2:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output handshake, checks stall hold.
    initial begin
        exp_t          e;
        bit            stall_prev;
        logic [DW-1:0] held;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            if (done) done_cnt++;
            if (bus.bias_rd_conf) rd_cnt++;
            if (stall_prev) begin
                check("stall_valid_hold", DW'(bus.out_valid), DW'(1));
                check("stall_data_hold", bus.data_out, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_output: got %h, want no output (cycle %0d)", bus.data_out, cyc);
                end else begin
                    e = sb.pop_front();
                    check("data_out", bus.data_out, e.data);
                    $display("out cycle %0d data %h", cyc, bus.data_out);
                    if (lat_check) check("latency", DW'(cyc - e.acc_cyc), DW'(2));
                end
                last_fire_cyc = cyc;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = bus.data_out;
        end
    end

    task automatic start_tile(input int len, input int sh);
        @(posedge clk);
        #1;
        start     = 1'b1;
        tile_len  = len[15:0];
        out_shift = sh[4:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        if (len > 0) check("start_rd_conf", DW'({busy, bus.bias_rd_conf, done}), DW'(3'b110));
        else         check("start_zero_len", DW'({busy, bus.bias_rd_conf, done}), DW'(3'b001));
    endtask

    task automatic give_bias(input logic [BW-1:0] bv);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(negedge clk);
        check("wait_bias_ready_low", DW'(bus.psum_ready), DW'(0));
        @(posedge clk);
        #1;
        bus.bias_en = 1'b1;
        bus.bias_in = bv;
        @(posedge clk);
        #1;
        bus.bias_en = 1'b0;
        bus.bias_in = ~bv;
        @(negedge clk);
        check("run_ready_high", DW'(bus.psum_ready), DW'(1));
    endtask

    task automatic send_psum(input logic [PW-1:0] pv, input logic [DW-1:0] ev);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.psum_valid = 1'b1;
        bus.psum_in    = pv;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk);
            if (bus.psum_ready) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL psum_accept_timeout: ready stayed 0, want 1");
        end else begin
            e.data    = ev;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout: done stayed 0, want 1");
        end else begin
            check("done_after_last_out", DW'(cyc - last_fire_cyc), DW'(1));
            check("scoreboard_drained", DW'(sb.size()), DW'(0));
            @(negedge clk);
            check("done_one_cycle_idle", DW'({done, busy}), DW'(0));
        end
    endtask

    task automatic run_tile(input int len, input int sh, input bit fixed, input int pa, input int pb,
                            input int bfix, input int max_gap, input bit junk, input int abort_at);
        int              b[X_PE];
        int              p;
        int              gap;
        int              d0, r0;
        logic [BW-1:0]   bv;
        logic [PW-1:0]   pv;
        logic [DW-1:0]   ev;
        d0 = done_cnt;
        r0 = rd_cnt;
        $display("tile len %0d shift %0d", len, sh);
        for (int j = 0; j < X_PE; j++) begin
            b[j] = fixed ? bfix : int'($urandom_range(0, 2**20 - 1)) - 2**19;
            bv[j*BIAS_DATALEN +: BIAS_DATALEN] = b[j][BIAS_DATALEN-1:0];
        end
        start_tile(len, sh);
        give_bias(bv);
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) return;
            if (junk && i == 1) begin
                @(posedge clk);
                #1;
                bus.psum_valid = 1'b0;
                bus.bias_en    = 1'b1;
                bus.bias_in    = ~bv;
                start          = 1'b1;
                tile_len       = 16'd1;
                @(posedge clk);
                #1;
                bus.bias_en = 1'b0;
                start       = 1'b0;
            end
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                @(posedge clk);
                #1;
                bus.psum_valid = 1'b0;
                repeat (gap - 1) @(posedge clk);
            end
            for (int j = 0; j < X_PE; j++) begin
                p = fixed ? ((i % 2 == 0) ? pa : pb) : int'($urandom_range(0, 2**24 - 1)) - 2**23;
                pv[j*PSUM_LEN +: PSUM_LEN] = p[PSUM_LEN-1:0];
                ev[j*OUT_LEN +: OUT_LEN]   = ref_q(longint'(p), longint'(b[j]), sh);
            end
            send_psum(pv, ev);
        end
        @(posedge clk);
        #1;
        bus.psum_valid = 1'b0;
        wait_done();
        check("done_pulse_count", DW'(done_cnt - d0), DW'(1));
        check("rd_conf_count", DW'(rd_cnt - r0), DW'(1));
    endtask

    initial begin
        int d0, r0;
        start          = 1'b0;
        tile_len       = '0;
        out_shift      = '0;
        bus.bias_en    = 1'b0;
        bus.bias_in    = '0;
        bus.psum_valid = 1'b0;
        bus.psum_in    = '0;
        rst_n          = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_ctrl", DW'({busy, done, bus.psum_ready, bus.out_valid, bus.bias_rd_conf}), DW'(0));
        check("reset_data", bus.data_out, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Nominal tile: 116 -> (116+8)>>4 = 7 on every channel, 2-cycle latency.
        rdy_mode  = 0;
        lat_check = 1'b1;
        run_tile(3, 4, 1'b1, 100, 100, 16, 0, 1'b0, -1);
        lat_check = 1'b0;

        // Saturation both ways, no shift.
        run_tile(2, 0, 1'b1, 100000, -100000, 0, 0, 1'b0, -1);

        // Empty tile: done next cycle, no bias request.
        d0 = done_cnt;
        r0 = rd_cnt;
        start_tile(0, 3);
        @(negedge clk);
        check("zero_len_idle", DW'({busy, bus.bias_rd_conf, done}), DW'(0));
        check("zero_len_no_rd", DW'(rd_cnt - r0), DW'(0));
        check("zero_len_done_cnt", DW'(done_cnt - d0), DW'(1));

        // bias_en while IDLE must not wake the block.
        @(posedge clk);
        #1;
        bus.bias_en = 1'b1;
        bus.bias_in = {10{$urandom()}};
        @(posedge clk);
        #1;
        bus.bias_en = 1'b0;
        @(negedge clk);
        check("idle_bias_en_ignored", DW'({busy, bus.psum_ready, bus.bias_rd_conf, bus.out_valid}), DW'(0));

        // Backpressure with toggling out_ready, plus stray start/bias_en mid-tile.
        rdy_mode = 1;
        run_tile(8, int'($urandom_range(1, 8)), 1'b0, 0, 0, 0, 0, 1'b1, -1);
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        // Reset after 2 of 5 psums.
        run_tile(5, 3, 1'b0, 0, 0, 0, 0, 1'b0, 2);
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        bus.psum_valid = 1'b0;
        d0             = done_cnt;
        @(negedge clk);
        check("midtile_reset_ctrl", DW'({busy, done, bus.psum_ready, bus.out_valid, bus.bias_rd_conf}), DW'(0));
        check("midtile_reset_data", bus.data_out, '0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midtile_reset_no_done", DW'(done_cnt - d0), DW'(0));
        check("midtile_reset_idle", DW'({busy, bus.out_valid}), DW'(0));

        run_tile(4, 2, 1'b0, 0, 0, 0, 0, 1'b0, -1);

        // Random tiles under random backpressure and input gaps.
        rdy_mode = 2;
        for (int t = 0; t < 6; t++) begin
            run_tile(int'($urandom_range(1, 12)), int'($urandom_range(0, 15)),
                     1'b0, 0, 0, 0, 2, t[0], -1);
        end
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, want finish before 40000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
